// File: rtl/keccak_squeeze_packer_if.sv
// Source-word and output-beat signal bundle between the Keccak squeeze core, the packer and the sink.
// master = packer side, slave = environment (core + sink) side.
interface keccak_squeeze_packer_if #(
    parameter int IN_DWIDTH  = 256,
    parameter int OUT_DWIDTH = 64,
    parameter int LEN_WIDTH  = 16
);
    localparam int IN_BYTES  = IN_DWIDTH / 8;
    localparam int OUT_BYTES = OUT_DWIDTH / 8;

    logic                  start_i;
    logic [LEN_WIDTH-1:0]  out_len_i;
    logic [IN_DWIDTH-1:0]  s_data_i;
    logic                  s_valid_i;
    logic                  s_last_i;
    logic [IN_BYTES-1:0]   s_keep_i;
    logic                  s_ready_o;
    logic                  stop_o;
    logic [OUT_DWIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic [OUT_BYTES-1:0]  m_keep_o;
    logic                  m_ready_i;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  start_i, out_len_i, s_data_i, s_valid_i, s_last_i, s_keep_i, m_ready_i,
        output s_ready_o, stop_o, m_data_o, m_valid_o, m_last_o, m_keep_o, busy_o, done_o
    );

    modport slave (
        output start_i, out_len_i, s_data_i, s_valid_i, s_last_i, s_keep_i, m_ready_i,
        input  s_ready_o, stop_o, m_data_o, m_valid_o, m_last_o, m_keep_o, busy_o, done_o
    );
endinterface

// File: rtl/keccak_squeeze_packer.sv
// Splits wide squeeze words into OUT_DWIDTH beats, truncating to a byte length; first beat 1 cycle after
// word accept, one idle LOAD cycle per word; beats hold stable under m_ready_i low, s_ready_o only in LOAD.
module keccak_squeeze_packer #(
    parameter int IN_DWIDTH  = 256,
    parameter int OUT_DWIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    keccak_squeeze_packer_if.master bus
);
    localparam int IN_BYTES  = IN_DWIDTH / 8;
    localparam int OUT_BYTES = OUT_DWIDTH / 8;
    localparam int CNT_W     = $clog2(IN_BYTES + 1);
    localparam logic [CNT_W-1:0] OUT_BYTES_C = CNT_W'(OUT_BYTES);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t               state, state_n;
    logic [IN_DWIDTH-1:0] word_buf;
    logic [CNT_W-1:0]     byte_cnt;
    logic [LEN_WIDTH-1:0] len_rem;
    logic                 unlimited;
    logic                 word_last;
    logic                 s_ready_q;
    logic                 stop_q;
    logic                 done_q;

    logic [CNT_W-1:0]      n_word;
    logic [CNT_W-1:0]      n;
    logic [LEN_WIDTH-1:0]  n_ext;
    logic [CNT_W-1:0]      keep_cnt;
    logic                  len_hit;
    logic                  beat_last;
    logic [OUT_BYTES-1:0]  beat_keep;
    logic [OUT_DWIDTH-1:0] beat_data;
    logic                  accept;
    logic                  beat_fire;

    // Bytes in the current beat: limited by beat width, bytes left in the word and bytes left in the job.
    always_comb begin
        n_word = (byte_cnt < OUT_BYTES_C) ? byte_cnt : OUT_BYTES_C;
        n      = (!unlimited && (len_rem < LEN_WIDTH'(n_word))) ? len_rem[CNT_W-1:0] : n_word;
        n_ext  = LEN_WIDTH'(n);
        len_hit   = !unlimited && (len_rem == n_ext);
        beat_last = len_hit || (word_last && (byte_cnt == n));
        beat_keep = '0;
        beat_data = '0;
        for (int b = 0; b < OUT_BYTES; b++) begin
            beat_keep[b]       = (CNT_W'(b) < n);
            beat_data[8*b +: 8] = beat_keep[b] ? word_buf[8*b +: 8] : 8'h00;
        end
        keep_cnt = '0;
        for (int b = 0; b < IN_BYTES; b++) begin
            keep_cnt = keep_cnt + CNT_W'(bus.s_keep_i[b]);
        end
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        beat_fire = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_i) state_n = LOAD;
            end
            LOAD: begin
                if (bus.s_valid_i && s_ready_q) begin
                    accept = 1'b1;
                    // An empty word that does not close the stream carries nothing to emit.
                    if ((keep_cnt != '0) || bus.s_last_i) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.m_ready_i) begin
                    beat_fire = 1'b1;
                    if (beat_last)             state_n = IDLE;
                    else if (byte_cnt == n)    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_buf  <= '0;
            byte_cnt  <= '0;
            len_rem   <= '0;
            unlimited <= 1'b0;
            word_last <= 1'b0;
            s_ready_q <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            s_ready_q <= (state_n == LOAD);
            done_q    <= beat_fire && beat_last;
            if ((state == IDLE) && bus.start_i) begin
                len_rem   <= bus.out_len_i;
                unlimited <= (bus.out_len_i == '0);
                stop_q    <= 1'b0;
            end
            if (accept) begin
                word_buf  <= bus.s_data_i;
                byte_cnt  <= keep_cnt;
                word_last <= bus.s_last_i;
            end
            if (beat_fire) begin
                word_buf <= word_buf >> OUT_DWIDTH;
                byte_cnt <= byte_cnt - n;
                len_rem  <= (len_rem > n_ext) ? (len_rem - n_ext) : '0;
                // Length ran out before the core signalled its final word: make the core stop squeezing.
                if (beat_last && len_hit && !word_last) stop_q <= 1'b1;
            end
        end
    end

    assign bus.s_ready_o = s_ready_q;
    assign bus.stop_o    = stop_q;
    assign bus.done_o    = done_q;
    assign bus.busy_o    = (state != IDLE);
    assign bus.m_valid_o = (state == DRAIN);
    assign bus.m_data_o  = (state == DRAIN) ? beat_data : '0;
    assign bus.m_keep_o  = (state == DRAIN) ? beat_keep : '0;
    assign bus.m_last_o  = (state == DRAIN) && beat_last;
endmodule
